// File: rtl/conv_mac_pipe_if.sv
// conv_mac_pipe_if: bundles the coefficient-load, window and result streams of conv_mac_pipe.
// Latency: none (wires only).
// Backpressure: kw_ready / win_ready toward the source, out_ready from the sink.
// Ports: kw_valid/kw_data/kw_ready (coefficient load), kernel_clear/kernel_loaded (kernel control),
//        win_valid/win_data/win_ready (pixel windows), out_valid/out_data/out_ready (results).
// master = stimulus/source side, slave = the engine.
interface conv_mac_pipe_if #(
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int OUT_W = 20
);
  logic                 kw_valid;
  logic [DW-1:0]        kw_data;
  logic                 kw_ready;
  logic                 kernel_clear;
  logic                 kernel_loaded;
  logic                 win_valid;
  logic [K*K*DW-1:0]    win_data;
  logic                 win_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic                 out_ready;

  modport master (
    output kw_valid, kw_data, kernel_clear, win_valid, win_data, out_ready,
    input  kw_ready, kernel_loaded, win_ready, out_valid, out_data
  );

  modport slave (
    input  kw_valid, kw_data, kernel_clear, win_valid, win_data, out_ready,
    output kw_ready, kernel_loaded, win_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: KxK convolution multiply-accumulate, serially loaded kernel, saturated result.
// Latency: 3 cycles from window acceptance to out_valid; 1 window/cycle throughput.
// Backpressure: whole pipeline holds while out_valid && !out_ready; win_ready drops meanwhile.
// Ports: clk, rst (async, active-high), bus (conv_mac_pipe_if.slave: kw_*, kernel_clear,
//        kernel_loaded, win_*, out_*).
// Optional build macro CONV_RELU_EN: clamp negative (SIGNED=1) results to zero in the output stage.
module conv_mac_pipe #(
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int OUT_W  = 20
) (
  input  logic           clk,
  input  logic           rst,
  conv_mac_pipe_if.slave bus
);
  localparam int TAPS  = K * K;
  localparam int PW    = 2 * DW;
  localparam int ACC_W = 2 * DW + $clog2(TAPS);
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    taps_q [TAPS];
  logic             clear_pending_q;

  logic [PW-1:0]    prod_q [TAPS];
  logic             s1_valid_q;
  logic [ACC_W-1:0] sum_d, sum_q;
  logic             s2_valid_q;
  logic [OUT_W-1:0] res_sat, res_d;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;

  logic stall, pipe_empty, kw_fire, win_fire;

  assign stall      = out_valid_q && !bus.out_ready;
  assign pipe_empty = !s1_valid_q && !s2_valid_q && !out_valid_q;

  // kw_ready is forced low while reset is held so nothing is accepted mid-reset.
  assign bus.kw_ready      = !rst && (state_q != RUN);
  assign bus.kernel_loaded = (state_q == RUN);
  assign bus.win_ready     = (state_q == RUN) && !clear_pending_q && !stall;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;

  assign kw_fire  = bus.kw_valid && bus.kw_ready;
  assign win_fire = bus.win_valid && bus.win_ready;

  // Operands are extended to the product width first; the low 2*DW bits of the
  // wide product are then the exact (two's complement when signed) result.
  function automatic logic [PW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] ax, bx;
    if (SIGNED != 0) begin
      ax = PW'($signed(a));
      bx = PW'($signed(b));
    end else begin
      ax = PW'(a);
      bx = PW'(b);
    end
    return ax * bx;
  endfunction

  // ---------------- kernel load FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (bus.kernel_clear) state_d = EMPTY;
        else if (kw_fire)     state_d = (TAPS == 1) ? RUN : LOAD;
      end
      LOAD: begin
        if (bus.kernel_clear)                state_d = EMPTY;
        else if (kw_fire && cnt_q == LAST)   state_d = RUN;
      end
      RUN: begin
        // The kernel is only dropped once every in-flight window has drained.
        if (clear_pending_q && pipe_empty)   state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= EMPTY;
      cnt_q           <= '0;
      clear_pending_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        EMPTY, LOAD: begin
          clear_pending_q <= 1'b0;
          if (bus.kernel_clear) begin
            cnt_q <= '0;
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
          end else if (kw_fire) begin
            taps_q[cnt_q] <= bus.kw_data;
            cnt_q         <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (clear_pending_q && pipe_empty) begin
            clear_pending_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
          end else if (bus.kernel_clear) begin
            clear_pending_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- arithmetic ----------------
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (SIGNED != 0) sum_d = sum_d + ACC_W'($signed(prod_q[i]));
      else             sum_d = sum_d + ACC_W'(prod_q[i]);
    end
  end

  generate
    if (OUT_W >= ACC_W) begin : g_extend
      always_comb begin
        if (SIGNED != 0) res_sat = OUT_W'($signed(sum_q));
        else             res_sat = OUT_W'(sum_q);
      end
    end else begin : g_saturate
      always_comb begin
        res_sat = sum_q[OUT_W-1:0];
        if (SIGNED != 0) begin
          // In range only if every bit from the output sign bit upward agrees.
          if (!((&sum_q[ACC_W-1:OUT_W-1]) || !(|sum_q[ACC_W-1:OUT_W-1])))
            res_sat = sum_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          if (|sum_q[ACC_W-1:OUT_W]) res_sat = '1;
        end
      end
    end
  endgenerate

  always_comb begin
    res_d = res_sat;
`ifdef CONV_RELU_EN
    if ((SIGNED != 0) && res_sat[OUT_W-1]) res_d = '0;
`else
    res_d = res_sat;
`endif
  end

  // ---------------- 3-stage pipeline ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
    end else if (!stall) begin
      s1_valid_q <= win_fire;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= mul(bus.win_data[i*DW +: DW], taps_q[i]);
      s2_valid_q  <= s1_valid_q;
      sum_q       <= sum_d;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) out_data_q <= res_d;
    end
  end
endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: scoreboard bench for conv_mac_pipe (unsigned/20, unsigned/16, signed/20 in lockstep).
// Latency: checks the 3-cycle window-to-result latency directly.
// Backpressure: drives out_ready low mid-stream and checks hold/ordering.
module tb_conv_mac_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        kw_valid, kernel_clear, win_valid, out_ready;
  logic [7:0]  kw_data;
  logic [71:0] win_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] ker [9];
  int         tap_idx = 0;
  longint     exp_a[$], exp_b[$], exp_s[$];

  always #5 clk = ~clk;

  conv_mac_pipe_if #(.K(3), .DW(8), .OUT_W(20)) ifa ();
  conv_mac_pipe_if #(.K(3), .DW(8), .OUT_W(16)) ifb ();
  conv_mac_pipe_if #(.K(3), .DW(8), .OUT_W(20)) ifs ();

  assign ifa.kw_valid = kw_valid;  assign ifb.kw_valid = kw_valid;  assign ifs.kw_valid = kw_valid;
  assign ifa.kw_data  = kw_data;   assign ifb.kw_data  = kw_data;   assign ifs.kw_data  = kw_data;
  assign ifa.kernel_clear = kernel_clear;
  assign ifb.kernel_clear = kernel_clear;
  assign ifs.kernel_clear = kernel_clear;
  assign ifa.win_valid = win_valid; assign ifb.win_valid = win_valid; assign ifs.win_valid = win_valid;
  assign ifa.win_data  = win_data;  assign ifb.win_data  = win_data;  assign ifs.win_data  = win_data;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifs.out_ready = out_ready;

  conv_mac_pipe #(.K(3), .DW(8), .SIGNED(0), .OUT_W(20)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  conv_mac_pipe #(.K(3), .DW(8), .SIGNED(0), .OUT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  conv_mac_pipe #(.K(3), .DW(8), .SIGNED(1), .OUT_W(20)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

  // Reference dot product with saturation (and ReLU when built with it).
  function automatic longint model(input logic [71:0] w, input bit sgn, input int ow);
    longint acc, a, b, hi, lo;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      if (sgn) begin a = longint'($signed(ker[i])); b = longint'($signed(w[i*8 +: 8])); end
      else     begin a = longint'(ker[i]);          b = longint'(w[i*8 +: 8]);          end
      acc += a * b;
    end
    if (sgn) begin
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -hi - 1;
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
    end else begin
      hi = (longint'(1) << ow) - 1;
      if (acc > hi) acc = hi;
    end
    return acc;
  endfunction

  // Scoreboard: pops one expected value per DUT per completed output handshake.
  always @(negedge clk) begin
    longint e;
    if (rst === 1'b0 && out_ready) begin
      if (ifa.out_valid) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL sb_a unexpected result %0d", ifa.out_data); end
        else begin
          e = exp_a.pop_front();
          if (longint'(ifa.out_data) !== e) begin errors++; $display("FAIL sb_a got %0d exp %0d", ifa.out_data, e); end
        end
      end
      if (ifb.out_valid) begin
        checks++;
        if (exp_b.size() == 0) begin errors++; $display("FAIL sb_b unexpected result %0d", ifb.out_data); end
        else begin
          e = exp_b.pop_front();
          if (longint'(ifb.out_data) !== e) begin errors++; $display("FAIL sb_b got %0d exp %0d", ifb.out_data, e); end
        end
      end
      if (ifs.out_valid) begin
        checks++;
        if (exp_s.size() == 0) begin errors++; $display("FAIL sb_s unexpected result %0d", $signed(ifs.out_data)); end
        else begin
          e = exp_s.pop_front();
          if (longint'($signed(ifs.out_data)) !== e) begin
            errors++; $display("FAIL sb_s got %0d exp %0d", $signed(ifs.out_data), e);
          end
        end
      end
    end
  end

  task automatic load_taps(input logic [7:0] v, input int n);
    bit acc;
    for (int t = 0; t < n; t++) begin
      acc = 0; kw_valid = 1'b1; kw_data = v;
      for (int c = 0; c < 100 && !acc; c++) begin
        @(negedge clk); acc = ifa.kw_ready; @(posedge clk);
      end
      if (!acc) begin checks++; errors++; $display("FAIL kw_accept timeout tap %0d", t); end
      else if (tap_idx < 9) begin ker[tap_idx] = v; tap_idx++; end
      #1;
    end
    kw_valid = 1'b0;
  endtask

  task automatic load_kernel(input logic [7:0] v);
    tap_idx = 0;
    load_taps(v, 9);
    tap_idx = 0;
    checks++; if (ifa.kernel_loaded !== 1'b1) begin errors++; $display("FAIL loaded got %b exp 1", ifa.kernel_loaded); end
    checks++; if (ifa.kw_ready !== 1'b0) begin errors++; $display("FAIL run_kw_ready got %b exp 0", ifa.kw_ready); end
    checks++; if (ifa.win_ready !== 1'b1) begin errors++; $display("FAIL run_win_ready got %b exp 1", ifa.win_ready); end
  endtask

  task automatic send_window(input logic [71:0] w);
    bit acc;
    acc = 0; win_valid = 1'b1; win_data = w;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk); acc = ifa.win_ready; @(posedge clk);
    end
    if (!acc) begin checks++; errors++; $display("FAIL win_accept timeout"); end
    else begin
      exp_a.push_back(model(w, 0, 20));
      exp_b.push_back(model(w, 0, 16));
      exp_s.push_back(model(w, 1, 20));
    end
    #1;
  endtask

  task automatic wait_out();
    bit seen;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (ifa.out_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL out_valid timeout"); end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && (exp_a.size() + exp_b.size() + exp_s.size()) != 0; c++) @(posedge clk);
    #1;
    checks++;
    if ((exp_a.size() + exp_b.size() + exp_s.size()) != 0) begin
      errors++; $display("FAIL drain pending %0d exp 0", exp_a.size() + exp_b.size() + exp_s.size());
    end
  endtask

  task automatic clear_kernel();
    kernel_clear = 1'b1; @(posedge clk); #1; kernel_clear = 1'b0;
    for (int c = 0; c < 50 && ifa.kernel_loaded; c++) begin @(posedge clk); #1; end
    tap_idx = 0;
    checks++; if (ifa.kernel_loaded !== 1'b0) begin errors++; $display("FAIL clear_loaded got %b exp 0", ifa.kernel_loaded); end
    checks++; if (ifa.kw_ready !== 1'b1) begin errors++; $display("FAIL clear_kw_ready got %b exp 1", ifa.kw_ready); end
  endtask

  function automatic logic [71:0] fill(input logic [7:0] v);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [71:0] ramp();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(i + 1);
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; kw_valid = 0; kw_data = 0; kernel_clear = 0; win_valid = 0; win_data = 0; out_ready = 1;
    #12;
    checks++; if (ifa.kw_ready !== 1'b0) begin errors++; $display("FAIL rst_kw_ready got %b exp 0", ifa.kw_ready); end
    checks++; if (ifa.kernel_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got %b exp 0", ifa.kernel_loaded); end
    checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL rst_win_ready got %b exp 0", ifa.win_ready); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.out_data !== 20'd0) begin errors++; $display("FAIL rst_out_data got %0d exp 0", ifa.out_data); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifa.kw_ready !== 1'b1) begin errors++; $display("FAIL empty_kw_ready got %b exp 1", ifa.kw_ready); end
    checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL empty_win_ready got %b exp 0", ifa.win_ready); end
  endtask

  task automatic test_latency();
    load_kernel(8'd1);
    send_window(ramp());
    win_valid = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL lat_c1 got %b exp 0", ifa.out_valid); end
    @(posedge clk); #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL lat_c2 got %b exp 0", ifa.out_valid); end
    @(posedge clk); #1;
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL lat_c3 got %b exp 1", ifa.out_valid); end
    checks++; if (ifa.out_data !== 20'd45) begin errors++; $display("FAIL ones_ramp got %0d exp 45", ifa.out_data); end
    wait_drain();
    // A coefficient word offered while running must be ignored.
    kw_valid = 1'b1; kw_data = 8'h77;
    send_window(fill(8'd3));
    win_valid = 1'b0; kw_valid = 1'b0;
    wait_drain();
    checks++; if (ifa.kernel_loaded !== 1'b1) begin errors++; $display("FAIL kw_ignored_loaded got %b exp 1", ifa.kernel_loaded); end
  endtask

  task automatic test_saturate();
    clear_kernel();
    load_kernel(8'hFF);
    send_window(fill(8'hFF));
    win_valid = 1'b0;
    wait_out();
    checks++; if (ifa.out_data !== 20'd585225) begin errors++; $display("FAIL max_u20 got %0d exp 585225", ifa.out_data); end
    checks++; if (ifb.out_data !== 16'd65535) begin errors++; $display("FAIL sat_u16 got %0d exp 65535", ifb.out_data); end
    wait_drain();
  endtask

  task automatic test_signed();
    logic [19:0] e;
    clear_kernel();
    load_kernel(8'hFF);
    send_window(fill(8'd2));
    win_valid = 1'b0;
    wait_out();
`ifdef CONV_RELU_EN
    e = 20'd0;
`else
    e = 20'hFFFEE;
`endif
    checks++; if (ifs.out_data !== e) begin errors++; $display("FAIL signed_m18 got %0h exp %0h", ifs.out_data, e); end
    checks++; if (ifa.out_data !== 20'd4590) begin errors++; $display("FAIL unsigned_ff2 got %0d exp 4590", ifa.out_data); end
    wait_drain();
    clear_kernel();
    load_kernel(8'h01);
    send_window(fill(8'h80));
    win_valid = 1'b0;
    wait_out();
`ifdef CONV_RELU_EN
    e = 20'd0;
`else
    e = 20'hFFB80;
`endif
    checks++; if (ifs.out_data !== e) begin errors++; $display("FAIL signed_m1152 got %0h exp %0h", ifs.out_data, e); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bit held, saw_stall;
    logic [19:0] cap;
    held = 0; saw_stall = 0; cap = '0;
    fork
      begin
        for (int n = 0; n < 6; n++) send_window({$urandom, $urandom, 8'($urandom)});
        win_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 12; cyc++) begin
          @(posedge clk); #1;
          if (cyc == 3) out_ready = 1'b0;
          if (cyc == 8) out_ready = 1'b1;
        end
      end
      begin
        for (int cyc = 0; cyc < 14; cyc++) begin
          @(negedge clk);
          if (!out_ready) begin
            if (held) begin
              checks++;
              if (ifa.out_valid !== 1'b1 || ifa.out_data !== cap) begin
                errors++; $display("FAIL stall_hold got %b/%0d exp 1/%0d", ifa.out_valid, ifa.out_data, cap);
              end
            end else if (ifa.out_valid) begin
              held = 1; cap = ifa.out_data; saw_stall = 1;
            end
            if (ifa.out_valid) begin
              checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL stall_win_ready got %b exp 0", ifa.win_ready); end
            end
          end else held = 0;
        end
      end
    join
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL stall_seen got %b exp 1", saw_stall); end
    wait_drain();
  endtask

  task automatic test_clear_inflight();
    send_window(ramp());
    send_window(fill(8'd7));
    win_valid = 1'b0;
    kernel_clear = 1'b1; @(posedge clk); #1; kernel_clear = 1'b0;
    checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL pend_win_ready got %b exp 0", ifa.win_ready); end
    checks++; if (ifa.kernel_loaded !== 1'b1) begin errors++; $display("FAIL pend_loaded got %b exp 1", ifa.kernel_loaded); end
    for (int c = 0; c < 50 && ifa.kernel_loaded; c++) begin @(posedge clk); #1; end
    tap_idx = 0;
    checks++; if ((exp_a.size() + exp_s.size()) != 0) begin errors++; $display("FAIL inflight_lost pending %0d exp 0", exp_a.size() + exp_s.size()); end
    checks++; if (ifa.kernel_loaded !== 1'b0) begin errors++; $display("FAIL post_clear_loaded got %b exp 0", ifa.kernel_loaded); end
    checks++; if (ifa.kw_ready !== 1'b1) begin errors++; $display("FAIL post_clear_kw_ready got %b exp 1", ifa.kw_ready); end
    load_kernel(8'd2);
    send_window(ramp());
    win_valid = 1'b0;
    wait_out();
    checks++; if (ifa.out_data !== 20'd90) begin errors++; $display("FAIL twos_ramp got %0d exp 90", ifa.out_data); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    clear_kernel();
    load_taps(8'd5, 4);
    rst = 1'b1; #1;
    checks++; if (ifa.kw_ready !== 1'b0) begin errors++; $display("FAIL midload_kw_ready got %b exp 0", ifa.kw_ready); end
    exp_a.delete(); exp_b.delete(); exp_s.delete(); tap_idx = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    load_taps(8'd3, 8);
    checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL partial_win_ready got %b exp 0", ifa.win_ready); end
    checks++; if (ifa.kernel_loaded !== 1'b0) begin errors++; $display("FAIL partial_loaded got %b exp 0", ifa.kernel_loaded); end
    load_taps(8'd3, 1);
    tap_idx = 0;
    checks++; if (ifa.win_ready !== 1'b1) begin errors++; $display("FAIL reload_win_ready got %b exp 1", ifa.win_ready); end
    send_window(ramp()); send_window(fill(8'd9)); send_window(fill(8'd1));
    win_valid = 1'b0;
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL prerst_out_valid got %b exp 1", ifa.out_valid); end
    rst = 1'b1; #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.kernel_loaded !== 1'b0) begin errors++; $display("FAIL midrst_loaded got %b exp 0", ifa.kernel_loaded); end
    exp_a.delete(); exp_b.delete(); exp_s.delete();
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL postrst_out_valid got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.win_ready !== 1'b0) begin errors++; $display("FAIL postrst_win_ready got %b exp 0", ifa.win_ready); end
    load_kernel(8'd1);
    send_window(fill(8'd4));
    win_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_saturate();
    test_signed();
    test_back_to_back();
    test_clear_inflight();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
